// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern source: FSM states, default frame
// width and the canonical detector test patterns.
package serial_pattern_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [2:0] PAT_111   = 3'b111;
  localparam logic [2:0] PAT_001   = 3'b001;
  localparam logic [7:0] PAT_BENCH = 8'b00111110;

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter with zero flag; tracks the bits still to be sent
// after the one currently on the serial output.
module bit_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serial_pattern_generator.sv
// Serial pattern source: accepts a word plus bit count on start/ready and
// shifts the selected bits out MSB-first, one per clock, with done on the last.
module serial_pattern_generator
  import serial_pattern_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned LEN_W      = $clog2(WIDTH + 1),
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             ready,
  output logic             o,
  output logic             o_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] aligned;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             accept;

  // Left-align the frame so bit len-1 sits at the MSB; shifting is then uniform.
  always_comb begin
    len_eff      = (len > WIDTH_L) ? WIDTH_L : len;
    aligned      = data << (WIDTH_L - len_eff);
    accept       = (state == IDLE) && start && (len != '0);
    cnt_load     = accept || ((state == SHIFT) && abort);
    cnt_load_val = accept ? (len_eff - LEN_W'(1)) : '0;
    cnt_dec      = (state == SHIFT) && !abort && !cnt_zero;
  end

  bit_down_counter #(
    .W (LEN_W)
  ) u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      o       <= IDLE_LEVEL;
      o_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            o       <= aligned[WIDTH-1];
            shreg   <= aligned << 1;
            o_valid <= 1'b1;
            done    <= (len_eff == LEN_W'(1));
          end
        end
        SHIFT: begin
          // done for the final bit was registered a cycle earlier, so a
          // last-cycle abort cannot retract it.
          if (abort || cnt_zero) begin
            state   <= IDLE;
            shreg   <= '0;
            o       <= IDLE_LEVEL;
            o_valid <= 1'b0;
            done    <= 1'b0;
          end else begin
            o     <= shreg[WIDTH-1];
            shreg <= shreg << 1;
            done  <= (cnt == LEN_W'(1));
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ready = (state == IDLE);
    busy  = (state == SHIFT);
  end

endmodule
